key_gate: RTL
=============

KEY_GATE -- requirements
Module: key_gate

Interface
REQ-001 Parameter KEY_VALUE, 16'h0032, the only accepted access key; it is also the value driven onto the granted access output.
REQ-002 Parameter MAX_FAILS, 3, consecutive failed attempts that trigger lockout; legal range 1..15.
REQ-003 Parameter SESSION_CYCLES, 256, length of a granted session in cycles; minimum 1.
REQ-004 Parameter LOCKOUT_CYCLES, 1024, length of a lockout in cycles; minimum 1.
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 key_valid  in  1  a key attempt is presented on key_in/key_target.
REQ-008 key_ready  out  1  block can accept an attempt this cycle.
REQ-009 key_in  in  16  candidate key.
REQ-010 key_target  in  1  0 = memory path, 1 = register path.
REQ-011 end_session  in  1  one-cycle request to close the current session early.
REQ-012 key_access_mem  out  16  key forwarded to the downstream security stage, memory path.
REQ-013 key_access_reg  out  16  key forwarded to the downstream security stage, register path.
REQ-014 session_active  out  1  high while in GRANT.
REQ-015 locked  out  1  high while in LOCKOUT.
REQ-016 fail_count  out  4  current count of consecutive failed attempts.

Function
REQ-017 Four states: IDLE, CHECK, GRANT, LOCKOUT. All outputs are registered, except key_ready, which is decoded from the state.
REQ-018 key_ready is 1 only in IDLE; an attempt is accepted on the rising edge where key_valid and key_ready are both 1, and key_in/key_target are captured into internal registers on that edge.
REQ-019 An accepted attempt moves IDLE to CHECK; CHECK lasts exactly one cycle; key_valid is ignored outside IDLE.
REQ-020 CHECK with captured key == KEY_VALUE: next state GRANT, fail_count cleared to 0, session counter loaded with SESSION_CYCLES-1.
REQ-021 CHECK with a mismatch: fail_count incremented; if the new value equals MAX_FAILS, next state LOCKOUT with lockout counter loaded LOCKOUT_CYCLES-1, otherwise next state IDLE.
REQ-022 In GRANT, the output selected by the captured target equals KEY_VALUE and the other output equals 16'h0000; both outputs are 16'h0000 in every other state.
REQ-023 Grant latency: the access output becomes valid on the second rising edge after the accepting edge.
REQ-024 GRANT decrements the session counter each cycle and returns to IDLE on the edge where the counter is 0 or end_session is 1; GRANT therefore lasts exactly SESSION_CYCLES cycles when not ended early.
REQ-025 end_session asserted together with counter == 0 gives a single return to IDLE; end_session outside GRANT has no effect.
REQ-026 On leaving GRANT, both access outputs are 16'h0000 from the same edge that enters IDLE.
REQ-027 LOCKOUT decrements the lockout counter and returns to IDLE with fail_count cleared on the edge where the counter is 0.
REQ-028 Counters never wrap; fail_count saturates at MAX_FAILS.

Reset
REQ-029 rst_n low forces, immediately and asynchronously: state IDLE, key_access_mem = key_access_reg = 16'h0000, session_active = 0, locked = 0, fail_count = 0, all counters and capture registers = 0.
REQ-030 Reset asserted mid-session or mid-lockout abandons that operation; the first cycle after release is IDLE with key_ready = 1.

Configuration
REQ-031 Macro KEY_GATE_STICKY_LOCK_EN defined: LOCKOUT is never left except by reset, and LOCKOUT_CYCLES is unused.
REQ-032 Macro KEY_GATE_STICKY_LOCK_EN undefined: LOCKOUT expires as in REQ-027.

Verification
REQ-033 Accept key_in=16'h0032, target=0 -> two edges later key_access_mem=16'h0032, key_access_reg=0, session_active=1 for exactly 256 cycles, then both outputs 0.
REQ-034 Accept 16'h0032, target=1, assert end_session 10 cycles into GRANT -> key_access_reg=16'h0032 then 0 on that edge; state IDLE, key_ready=1.
REQ-035 Three consecutive attempts with 16'h1234 -> fail_count 1,2,3; locked=1 and key_ready=0 for 1024 cycles; then locked=0 and fail_count=0.
REQ-036 Two wrong attempts then 16'h0032 -> fail_count returns to 0 and grant occurs; a following wrong attempt yields fail_count=1 with no lockout.
REQ-037 rst_n pulsed low mid-GRANT and mid-LOCKOUT -> all outputs 0 asynchronously; IDLE after release.
REQ-038 With KEY_GATE_STICKY_LOCK_EN defined, three wrong attempts -> locked stays 1 for 5000 cycles; cleared only by rst_n.

Source files
------------

// File: rtl/key_gate.sv
// Key-checking access gate: IDLE -> CHECK -> GRANT/LOCKOUT with a session timer and a failed-attempt lockout.
// Optional KEY_GATE_STICKY_LOCK_EN: once entered, LOCKOUT is left only by reset.
module key_gate #(
  parameter logic [15:0] KEY_VALUE      = 16'h0032,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned SESSION_CYCLES = 256,
  parameter int unsigned LOCKOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [15:0] key_in,
  input  logic        key_target,
  input  logic        end_session,
  output logic [15:0] key_access_mem,
  output logic [15:0] key_access_reg,
  output logic        session_active,
  output logic        locked,
  output logic [3:0]  fail_count
);

  localparam int unsigned SES_W  = $clog2(SESSION_CYCLES + 1);
  localparam logic [3:0]  FAIL_MAX = 4'(MAX_FAILS);

  typedef enum logic [1:0] {IDLE, CHECK, GRANT, LOCKOUT} state_e;

  state_e             state_q;
  logic [15:0]        key_q;
  logic               target_q;
  logic [SES_W-1:0]   ses_cnt_q;
  logic [15:0]        acc_mem_q;
  logic [15:0]        acc_reg_q;
  logic               session_q;
  logic               locked_q;
  logic [3:0]         fail_q;
  logic [3:0]         fail_d;

`ifndef KEY_GATE_STICKY_LOCK_EN
  localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  logic [LOCK_W-1:0]  lock_cnt_q;
`endif

  assign key_ready      = (state_q == IDLE);
  assign key_access_mem = acc_mem_q;
  assign key_access_reg = acc_reg_q;
  assign session_active = session_q;
  assign locked         = locked_q;
  assign fail_count     = fail_q;

  // Saturating increment so the count can never pass MAX_FAILS.
  always_comb begin
    fail_d = fail_q;
    if (fail_q < FAIL_MAX) fail_d = fail_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_q      <= '0;
      target_q   <= 1'b0;
      ses_cnt_q  <= '0;
      acc_mem_q  <= '0;
      acc_reg_q  <= '0;
      session_q  <= 1'b0;
      locked_q   <= 1'b0;
      fail_q     <= '0;
`ifndef KEY_GATE_STICKY_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            state_q  <= CHECK;
            key_q    <= key_in;
            target_q <= key_target;
          end
        end
        CHECK: begin
          if (key_q == KEY_VALUE) begin
            state_q   <= GRANT;
            fail_q    <= '0;
            ses_cnt_q <= SES_W'(SESSION_CYCLES - 1);
            session_q <= 1'b1;
            acc_mem_q <= target_q ? 16'h0000 : KEY_VALUE;
            acc_reg_q <= target_q ? KEY_VALUE : 16'h0000;
          end else begin
            fail_q <= fail_d;
            if (fail_d == FAIL_MAX) begin
              state_q    <= LOCKOUT;
              locked_q   <= 1'b1;
`ifndef KEY_GATE_STICKY_LOCK_EN
              lock_cnt_q <= LOCK_W'(LOCKOUT_CYCLES - 1);
`endif
            end else begin
              state_q <= IDLE;
            end
          end
        end
        GRANT: begin
          if (ses_cnt_q == '0 || end_session) begin
            state_q   <= IDLE;
            session_q <= 1'b0;
            acc_mem_q <= '0;
            acc_reg_q <= '0;
          end else begin
            ses_cnt_q <= ses_cnt_q - 1'b1;
          end
        end
        LOCKOUT: begin
`ifdef KEY_GATE_STICKY_LOCK_EN
          state_q <= LOCKOUT;
`else
          if (lock_cnt_q == '0) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
            fail_q   <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q - 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
